// File: rtl/seg7_digit_scanner.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// Holds a double-buffered BCD value and swaps it in only at frame boundaries.
module seg7_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          err_digit
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD_CNT = DW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]           div_cnt, div_nxt;
  logic [IW-1:0]           idx_nxt;
  logic                    primed;
  logic [4*NUM_DIGITS-1:0] act_bcd, act_bcd_nxt, pend_bcd;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt, pend_dp;
  logic                    pend_flag;
  logic                    boundary;
  logic [3:0]              nib_nxt;
  logic [NUM_DIGITS-1:0]   lead_blank;
  logic                    invalid_nxt;
  logic                    lit_nxt;

  assign boundary = primed && (div_cnt == DIV_LAST) && (digit_idx == IDX_LAST);

  // The first cycle after reset release holds slot 0 / count 0 so it can be
  // presented as the start of the first frame.
  always_comb begin
    div_nxt = div_cnt;
    idx_nxt = digit_idx;
    if (primed) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt = '0;
        idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    act_bcd_nxt = act_bcd;
    act_dp_nxt  = act_dp;
    if (boundary) begin
      if (load) begin
        act_bcd_nxt = bcd_in;
        act_dp_nxt  = dp_in;
      end else if (pend_flag) begin
        act_bcd_nxt = pend_bcd;
        act_dp_nxt  = pend_dp;
      end
    end
  end

  // Digit k is a leading zero when it and every more-significant nibble are 0.
  always_comb begin
    lead_blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lead_blank[k] = (BLANK_LEADING != 0);
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (act_bcd_nxt[4*j +: 4] != 4'd0) lead_blank[k] = 1'b0;
      end
    end
  end

  assign nib_nxt     = act_bcd_nxt[{idx_nxt, 2'b00} +: 4];
  assign invalid_nxt = (nib_nxt > 4'd9);
  assign lit_nxt     = (div_nxt >= GUARD_CNT) && !invalid_nxt && !lead_blank[idx_nxt];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed     <= 1'b0;
      div_cnt    <= '0;
      digit_idx  <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      bcd_out    <= 4'd0;
      an         <= '1;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
      err_digit  <= 1'b0;
    end else begin
      primed    <= 1'b1;
      div_cnt   <= div_nxt;
      digit_idx <= idx_nxt;
      act_bcd   <= act_bcd_nxt;
      act_dp    <= act_dp_nxt;
      if (boundary) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_bcd  <= bcd_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
      bcd_out    <= nib_nxt;
      an         <= lit_nxt ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
      dp_out     <= lit_nxt ? ~act_dp_nxt[idx_nxt] : 1'b1;
      frame_tick <= (div_nxt == '0) && (idx_nxt == '0);
      err_digit  <= invalid_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Scoreboard bench for seg7_digit_scanner: stimulus queues per-frame expectations,
// a monitor aligned to frame_tick checks every slot of each expected frame.
module tb_seg7_digit_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out, an, bcd_out2, an2;
  logic        dp_out, frame_tick, err_digit, dp_out2, frame_tick2, err_digit2;
  logic [1:0]  digit_idx, digit_idx2;

  seg7_digit_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .bcd_out(bcd_out), .an(an), .dp_out(dp_out), .digit_idx(digit_idx),
    .frame_tick(frame_tick), .err_digit(err_digit));

  seg7_digit_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .bcd_out(bcd_out2), .an(an2), .dp_out(dp_out2), .digit_idx(digit_idx2),
    .frame_tick(frame_tick2), .err_digit(err_digit2));

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    logic [15:0] val;
    logic [3:0] dp;
    logic [3:0] lit;   // digits that light, BLANK_LEADING=1
    logic [3:0] lit2;  // digits that light, BLANK_LEADING=0
    logic [3:0] err;
  } exp_t;

  exp_t q[$];
  int   frame_no = -1;
  int   errors = 0;
  int   checks = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) rst_q <= rst_n;

  task automatic push(input int f, input logic [15:0] v, input logic [3:0] d,
                      input logic [3:0] l, input logic [3:0] l2, input logic [3:0] e);
    exp_t x;
    x.frame = f; x.val = v; x.dp = d; x.lit = l; x.lit2 = l2; x.err = e;
    q.push_back(x);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0; bcd_in = 16'hFFFF; dp_in = 4'hF;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_tick: got no frame_tick within 100 cycles, need one");
  endtask

  initial begin : monitor
    exp_t        cur;
    bit          cur_valid = 0;
    bit          have_prev = 0;
    int          cyc = 0;
    int          since = 0;
    int          k, d;
    bit          bad[6];
    logic [7:0]  act_v[6];
    logic [7:0]  exp_v[6];
    logic [7:0]  a[6];
    logic [7:0]  e[6];
    string       nm[6];
    logic [3:0]  e_an, e_an2;
    logic        e_dp, e_dp2, ok2;
    nm = '{"digit_idx", "bcd_out", "an", "dp_out", "err_digit", "noblank_dut"};
    forever begin
      @(negedge clk);
      if (rst_q === 1'b0) begin
        checks++;
        if (an !== 4'hF || bcd_out !== 4'h0 || dp_out !== 1'b1 || frame_tick !== 1'b0 ||
            err_digit !== 1'b0 || digit_idx !== 2'd0) begin
          errors++;
          $display("FAIL reset_outputs: got an=%b bcd=%h dp=%b ft=%b err=%b idx=%0d, need an=1111 bcd=0 dp=1 ft=0 err=0 idx=0",
                   an, bcd_out, dp_out, frame_tick, err_digit, digit_idx);
        end
        cur_valid = 0; have_prev = 0;
        continue;
      end
      if (frame_tick === 1'b1) begin
        if (have_prev) begin
          checks++;
          if (since != 32) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles, need 32", since);
          end
        end
        have_prev = 1; since = 0; frame_no++;
        while (q.size() > 0 && q[0].frame < frame_no) begin
          checks++; errors++;
          $display("FAIL missed_frame: frame %0d never started on time, now at frame %0d", q[0].frame, frame_no);
          void'(q.pop_front());
        end
        cur_valid = 0;
        if (q.size() > 0 && q[0].frame == frame_no) begin
          cur = q.pop_front(); cur_valid = 1; cyc = 0;
        end
      end
      since++;
      if (cur_valid) begin
        k = cyc / 8; d = cyc % 8;
        if (d == 0) for (int i = 0; i < 6; i++) bad[i] = 0;
        e_an  = (d >= 2 && cur.lit[k])  ? ~(4'b0001 << k) : 4'hF;
        e_an2 = (d >= 2 && cur.lit2[k]) ? ~(4'b0001 << k) : 4'hF;
        e_dp  = (d >= 2 && cur.lit[k]  && cur.dp[k]) ? 1'b0 : 1'b1;
        e_dp2 = (d >= 2 && cur.lit2[k] && cur.dp[k]) ? 1'b0 : 1'b1;
        ok2 = (an2 === e_an2) && (dp_out2 === e_dp2) && (bcd_out2 === cur.val[4*k +: 4]) &&
              (err_digit2 === cur.err[k]) && (digit_idx2 === 2'(k)) && (frame_tick2 === (cyc == 0));
        a[0] = {6'd0, digit_idx};  e[0] = 8'(k);
        a[1] = {4'd0, bcd_out};    e[1] = {4'd0, cur.val[4*k +: 4]};
        a[2] = {4'd0, an};         e[2] = {4'd0, e_an};
        a[3] = {7'd0, dp_out};     e[3] = {7'd0, e_dp};
        a[4] = {7'd0, err_digit};  e[4] = {7'd0, cur.err[k]};
        a[5] = {3'd0, an2, dp_out2}; e[5] = {3'd0, e_an2, e_dp2};
        for (int i = 0; i < 6; i++) begin
          if (!bad[i] && ((i < 5 && a[i] !== e[i]) || (i == 5 && !ok2))) begin
            bad[i] = 1; act_v[i] = a[i]; exp_v[i] = e[i];
          end
        end
        if (d == 7) begin
          for (int i = 0; i < 6; i++) begin
            checks++;
            if (bad[i]) begin
              errors++;
              $display("FAIL %s frame %0d slot %0d: got %h, need %h", nm[i], frame_no, k, act_v[i], exp_v[i]);
            end
          end
        end
        cyc++;
        if (cyc == 32) cur_valid = 0;
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0000; dp_in = 4'h0;
    // reset and scan: blank display, only digit 0 lights
    push(0, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    push(1, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    wait_tick();
    // load mid-frame: frame 2 still shows 0, frame 3 shows 1234
    push(frame_no + 1, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    wait_tick();
    repeat (5) @(negedge clk);
    do_load(16'h1234, 4'b0101);
    push(frame_no + 1, 16'h1234, 4'b0101, 4'b1111, 4'b1111, 4'b0000);
    wait_tick();
    // load in the boundary cycle itself
    push(frame_no + 1, 16'h5678, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    repeat (31) @(negedge clk);
    do_load(16'h5678, 4'b0000);
    // two loads in one frame: only the last survives
    push(frame_no + 1, 16'h2222, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (5) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_tick();
    // leading-zero blanking
    push(frame_no + 1, 16'h0050, 4'b0000, 4'b0011, 4'b1111, 4'b0000);
    repeat (4) @(negedge clk);
    do_load(16'h0050, 4'b0000);
    wait_tick();
    push(frame_no + 1, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    repeat (4) @(negedge clk);
    do_load(16'h0000, 4'b0000);
    wait_tick();
    // invalid nibble in digit 2 with its decimal point requested
    push(frame_no + 1, 16'h1A23, 4'b0100, 4'b1011, 4'b1011, 4'b0100);
    push(frame_no + 2, 16'h1A23, 4'b0100, 4'b1011, 4'b1011, 4'b0100);
    repeat (4) @(negedge clk);
    do_load(16'h1A23, 4'b0100);
    wait_tick();
    wait_tick();
    wait_tick();
    // reset mid-frame discards the pending value
    repeat (2) @(negedge clk);
    do_load(16'h9999, 4'b1111);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    push(frame_no + 1, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    push(frame_no + 2, 16'h0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    wait_tick();
    repeat (40) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d unchecked frames, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
